clock_lock_monitor: RTL and testbench

CLOCK_LOCK_MONITOR -- requirements
Module: clock_lock_monitor

---
 rtl/clock_lock_monitor.sv | 166 ++++++++++++++++
 tb/tb_clock_lock_monitor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_lock_monitor.sv
// Measures reference and ADPLL clock periods in fpga_clk_i cycles and tracks lock.
// Latency: window results register one cycle after the synchronized ref edge pulse; no backpressure.
module clock_lock_monitor #(
  parameter int PERIOD_WIDTH = 12,
  parameter int TOLERANCE    = 2,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic                           fpga_clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic                           ref_clk_i,
  input  logic                           gen_clk_i,
  output logic        [PERIOD_WIDTH-1:0] period_ref_o,
  output logic        [PERIOD_WIDTH-1:0] period_gen_o,
  output logic signed [PERIOD_WIDTH:0]   period_diff_o,
  output logic                           valid_o,
  output logic                           lock_o
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_WIDTH:0]   TOL     = (PERIOD_WIDTH + 1)'(TOLERANCE);
  localparam logic [GW-1:0]           LOCK_N  = GW'(LOCK_COUNT);
  localparam logic [BW-1:0]           UNLK_N  = BW'(UNLOCK_COUNT);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRING, LOCKED} state_t;

  logic [2:0]              ref_sync, gen_sync;
  logic                    ref_pulse, gen_pulse;
  logic [PERIOD_WIDTH-1:0] ref_cnt, gen_cnt, ref_cnt_inc, gen_cnt_inc;
  logic [PERIOD_WIDTH-1:0] gen_per_q, gen_per_eff;
  logic                    ref_primed, gen_primed, gen_seen;
  logic                    win, gen_cap, gen_sat, ref_sat, good;
  logic signed [PERIOD_WIDTH:0] diff;
  logic        [PERIOD_WIDTH:0] abs_diff;
  state_t                  state_q, state_d;
  logic [GW-1:0]           good_q, good_d;
  logic [BW-1:0]           bad_q, bad_d;

  // Bits [1:0] are the two-flop synchronizer, bit [2] is the edge-detect history.
  assign ref_pulse = ref_sync[1] & ~ref_sync[2];
  assign gen_pulse = gen_sync[1] & ~gen_sync[2];

  assign ref_cnt_inc = (ref_cnt == CNT_MAX) ? CNT_MAX : ref_cnt + PERIOD_WIDTH'(1);
  assign gen_cnt_inc = (gen_cnt == CNT_MAX) ? CNT_MAX : gen_cnt + PERIOD_WIDTH'(1);

  assign win     = enable_i & ref_pulse & ref_primed;
  assign gen_cap = enable_i & gen_pulse & gen_primed;
  // A gen edge coinciding with the ref edge belongs to the window being closed.
  assign gen_per_eff = gen_cap ? gen_cnt_inc : gen_per_q;
  assign gen_sat     = (gen_cnt == CNT_MAX) & ~gen_pulse;
  assign ref_sat     = (ref_cnt == CNT_MAX);

  assign diff     = $signed({1'b0, gen_per_eff}) - $signed({1'b0, ref_cnt_inc});
  assign abs_diff = diff[PERIOD_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign good     = gen_primed & (gen_seen | gen_cap) & ~gen_sat & (abs_diff <= TOL);

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      ref_sync <= '0;
      gen_sync <= '0;
    end else begin
      ref_sync <= {ref_sync[1:0], ref_clk_i};
      gen_sync <= {gen_sync[1:0], gen_clk_i};
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i || !enable_i) begin
      ref_cnt    <= '0;
      gen_cnt    <= '0;
      ref_primed <= 1'b0;
      gen_primed <= 1'b0;
      gen_seen   <= 1'b0;
    end else begin
      ref_cnt <= ref_pulse ? '0 : ref_cnt_inc;
      gen_cnt <= gen_pulse ? '0 : gen_cnt_inc;
      if (ref_pulse) ref_primed <= 1'b1;
      if (gen_pulse) gen_primed <= 1'b1;
      if (ref_pulse)    gen_seen <= 1'b0;
      else if (gen_cap) gen_seen <= 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i)      gen_per_q <= '0;
    else if (gen_cap) gen_per_q <= gen_cnt_inc;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (win) begin
      case (state_q)
        UNLOCKED: begin
          if (good) begin
            state_d = ACQUIRING;
            good_d  = GW'(1);
          end
        end
        ACQUIRING: begin
          if (good) begin
            good_d = good_q + GW'(1);
            if (good_q + GW'(1) == LOCK_N) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            state_d = UNLOCKED;
            good_d  = '0;
          end
        end
        LOCKED: begin
          if (good) begin
            bad_d = '0;
          end else if (bad_q + BW'(1) == UNLK_N) begin
            state_d = UNLOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + BW'(1);
          end
        end
        default: begin
          state_d = UNLOCKED;
          good_d  = '0;
          bad_d   = '0;
        end
      endcase
    end
    // A stalled reference invalidates lock without waiting for another window.
    if (!enable_i || ref_sat) begin
      state_d = UNLOCKED;
      good_d  = '0;
      bad_d   = '0;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q       <= UNLOCKED;
      good_q        <= '0;
      bad_q         <= '0;
      valid_o       <= 1'b0;
      lock_o        <= 1'b0;
      period_ref_o  <= '0;
      period_gen_o  <= '0;
      period_diff_o <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      valid_o <= win;
      lock_o  <= (state_d == LOCKED);
      if (win) begin
        period_ref_o  <= ref_cnt_inc;
        period_gen_o  <= gen_per_eff;
        period_diff_o <= diff;
      end
    end
  end

endmodule

// File: tb/tb_clock_lock_monitor.sv
// Scoreboard bench: ref/gen clocks are generated on fpga_clk_i negedges and an edge-timestamp
// model predicts every window result, which is compared when valid_o pulses.
module tb_clock_lock_monitor;
  localparam int PW = 12;

  logic          fpga_clk_i = 1'b0;
  logic          reset_i, enable_i;
  logic          ref_clk_i = 1'b0;
  logic          gen_clk_i = 1'b0;
  logic [PW-1:0] period_ref_o, period_gen_o;
  logic signed [PW:0] period_diff_o;
  logic          valid_o, lock_o;

  clock_lock_monitor #(.PERIOD_WIDTH(PW), .TOLERANCE(2), .LOCK_COUNT(8), .UNLOCK_COUNT(2)) dut (
    .fpga_clk_i   (fpga_clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .ref_clk_i    (ref_clk_i),
    .gen_clk_i    (gen_clk_i),
    .period_ref_o (period_ref_o),
    .period_gen_o (period_gen_o),
    .period_diff_o(period_diff_o),
    .valid_o      (valid_o),
    .lock_o       (lock_o)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  typedef struct {
    int rp;
    int gp;
    int diff;
    bit lock;
    bit chk_gap;
  } win_t;
  win_t exp_q[$];

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus generator state
  int ref_per = 32, gen_per = 32, ref_ph = 0, gen_ph = 0, tcyc = 0, ref_edges = 0;
  bit ref_run = 0, gen_run = 0, ref_nxt, gen_nxt;

  // Edge-timestamp reference model
  bit m_ref_primed, m_gen_primed, m_gen_seen, m_prev_win;
  int m_last_ref, m_last_gen, m_gen_p, m_state, m_good, m_bad;

  task automatic model_reset(input bit full);
    m_ref_primed = 0; m_gen_primed = 0; m_gen_seen = 0; m_prev_win = 0;
    m_state = 0; m_good = 0; m_bad = 0;
    if (full) m_gen_p = 0;
  endtask

  task automatic model_gen_edge();
    if (m_gen_primed) begin
      m_gen_p = tcyc - m_last_gen;
      if (m_gen_p > 4095) m_gen_p = 4095;
      m_gen_seen = 1;
    end
    m_gen_primed = 1;
    m_last_gen = tcyc;
  endtask

  task automatic model_ref_edge();
    win_t w;
    int rp, d;
    bit ok;
    if (m_ref_primed) begin
      rp = tcyc - m_last_ref;
      if (rp > 4095) rp = 4095;
      d = m_gen_p - rp;
      ok = m_gen_primed && m_gen_seen && ((tcyc - m_last_gen) < 4096) && (d <= 2) && (d >= -2);
      case (m_state)
        0: if (ok) begin m_state = 1; m_good = 1; end
        1: if (ok) begin m_good++; if (m_good == 8) m_state = 2; end
           else begin m_state = 0; m_good = 0; end
        default: if (ok) m_bad = 0;
                 else begin m_bad++; if (m_bad == 2) begin m_state = 0; m_good = 0; m_bad = 0; end end
      endcase
      w = '{rp, m_gen_p, d, (m_state == 2), m_prev_win};
      exp_q.push_back(w);
    end
    m_prev_win = m_ref_primed;
    m_ref_primed = 1;
    m_last_ref = tcyc;
    m_gen_seen = 0;
  endtask

  always @(negedge fpga_clk_i) begin
    tcyc++;
    if (!ref_run) ref_ph = ref_per - 1;
    else if (ref_ph >= ref_per - 1) ref_ph = 0;
    else ref_ph++;
    if (!gen_run) gen_ph = gen_per - 1;
    else if (gen_ph >= gen_per - 1) gen_ph = 0;
    else gen_ph++;
    ref_nxt = ref_run && (ref_ph < ref_per / 2);
    gen_nxt = gen_run && (gen_ph < gen_per / 2);
    if (gen_nxt && !gen_clk_i) model_gen_edge();
    if (ref_nxt && !ref_clk_i) begin
      model_ref_edge();
      ref_edges++;
    end
    ref_clk_i = ref_nxt;
    gen_clk_i = gen_nxt;
  end

  // Output monitor
  int mcyc = 0, last_vcyc = 0, fall_cyc = 0, seg_win = 0, lock_win = 0;
  bit lock_prev = 0, lock_seen = 0;
  win_t got_w;

  always @(negedge fpga_clk_i) begin
    mcyc++;
    if (!lock_o && lock_prev) fall_cyc = mcyc;
    if (lock_o) lock_seen = 1;
    lock_prev = lock_o;
    if (valid_o === 1'b1) begin
      seg_win++;
      if (exp_q.size() == 0) check("spurious_valid", 1, 0);
      else begin
        got_w = exp_q.pop_front();
        check("period_ref", period_ref_o, got_w.rp);
        check("period_gen", period_gen_o, got_w.gp);
        check("period_diff", period_diff_o, got_w.diff);
        check("window_lock", lock_o, got_w.lock);
        if (got_w.chk_gap) check("valid_gap", mcyc - last_vcyc, got_w.rp);
      end
      if (lock_o && lock_win == 0) lock_win = seg_win;
      last_vcyc = mcyc;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge fpga_clk_i);
      #1;
    end
  endtask

  task automatic wait_ref();
    int n0;
    bit seen;
    n0 = ref_edges;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycles(1);
      if (ref_edges != n0) seen = 1;
    end
    if (!seen) check("wait_ref_timeout", 0, 1);
  endtask

  task automatic wait_win(input string tag, input int n);
    for (int i = 0; i < n * 40 + 200; i++) begin
      if (seg_win >= n) break;
      cycles(1);
    end
    check(tag, seg_win >= n, 1);
  endtask

  task automatic restart(input int rp, input int gp);
    ref_run = 0;
    gen_run = 0;
    enable_i = 1;
    cycles(40);
    check("queue_drained", exp_q.size(), 0);
    reset_i = 1;
    model_reset(1);
    cycles(1);
    reset_i = 0;
    ref_per = rp;
    gen_per = gp;
    seg_win = 0;
    lock_win = 0;
    lock_seen = 0;
    ref_run = 1;
    gen_run = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1;
    enable_i = 1;
    model_reset(1);
    cycles(3);
    check("rst_period_ref", period_ref_o, 0);
    check("rst_period_gen", period_gen_o, 0);
    check("rst_period_diff", period_diff_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_lock", lock_o, 0);
    reset_i = 0;

    // In-phase 32/32: lock on the 8th window after priming
    restart(32, 32);
    wait_win("win_a", 12);
    check("lock_window_a", lock_win, 8);
    check("diff_a", period_diff_o, 0);

    // Gen stalls while locked: two bad windows drop lock
    wait_ref();
    cycles(5);
    gen_run = 0;
    wait_win("win_gen_low", seg_win + 2);
    check("gen_low_unlock", lock_o, 0);

    // Reference stops while locked: lock falls when the ref counter saturates
    restart(32, 32);
    wait_win("win_c", 10);
    check("locked_before_ref_stop", lock_o, 1);
    wait_ref();
    cycles(5);
    ref_run = 0;
    fall_cyc = 0;
    for (int i = 0; i < 4400; i++) begin
      if (!lock_o) break;
      cycles(1);
    end
    check("ref_stop_unlock", lock_o, 0);
    check("ref_stop_delay", fall_cyc - last_vcyc, 4096);

    // Gen 40 vs ref 32: out of tolerance, never locks
    restart(32, 40);
    wait_win("win_d", 12);
    check("no_lock_40", lock_seen, 0);
    check("period_gen_40", period_gen_o, 40);
    check("diff_40", period_diff_o, 8);

    // Gen 34 vs ref 32: at tolerance edge, locks
    restart(32, 34);
    wait_win("win_e", 24);
    check("lock_34", lock_seen, 1);

    // Coincident ref/gen edges with gen period stepping to 33
    restart(32, 32);
    wait_win("win_f", 10);
    wait_ref();
    cycles(5);
    gen_per = 31;
    wait_ref();
    cycles(5);
    gen_per = 33;
    wait_ref();
    cycles(5);
    gen_per = 32;
    check("coincide_diff", period_diff_o, 1);
    check("coincide_gen", period_gen_o, 33);
    check("coincide_lock", lock_o, 1);

    // One-cycle enable drop while locked
    wait_ref();
    cycles(15);
    enable_i = 0;
    model_reset(0);
    cycles(1);
    check("en_drop_lock", lock_o, 0);
    check("en_drop_valid", valid_o, 0);
    enable_i = 1;
    seg_win = 0;
    lock_win = 0;
    wait_win("win_g", 10);
    check("relock_after_enable", lock_win, 8);

    // Reset pulse while locked
    wait_ref();
    cycles(20);
    reset_i = 1;
    model_reset(1);
    cycles(1);
    reset_i = 0;
    check("mid_rst_lock", lock_o, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_period_ref", period_ref_o, 0);
    check("mid_rst_diff", period_diff_o, 0);
    seg_win = 0;
    lock_win = 0;
    wait_win("win_h", 10);
    check("relock_after_reset", lock_win, 8);

    ref_run = 0;
    gen_run = 0;
    cycles(40);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
